// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of the tri-stated ALU: takes a request, drives the ALU for
// SETTLE_CYCLES with output_enable high, captures result/flags, and returns a response.
module alu_op_sequencer #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [3:0]        req_func,
  input  logic              req_update_flags,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [3:0]        alu_func,
  output logic              alu_output_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero_flag,
  input  logic              alu_positive_flag,
  input  logic              alu_carry_flag,
  input  logic              alu_signed_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic [3:0]        flags_q,
  output logic              busy
);

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_DRIVE = 2'd1;
  localparam logic [1:0] STATE_RESP  = 2'd2;

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_INV = 4'd5;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        func_q, func_d;
  logic              upd_q, upd_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic [3:0]        flags_d;
  logic              accept;
  logic              func_legal;
  logic              func_arith;

  assign func_legal = (req_func <= FUNC_INV);
  assign func_arith = (func_q == FUNC_ADD) || (func_q == FUNC_SUB);

  always_comb begin
    req_ready = !reset && ((state_q == STATE_IDLE) ||
                           ((state_q == STATE_RESP) && rsp_ready));
    accept    = req_valid && req_ready;

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    func_d   = func_q;
    upd_d    = upd_q;
    oe_d     = oe_q;
    result_d = result_q;
    err_d    = err_q;
    flags_d  = flags_q;

    case (state_q)
      STATE_DRIVE: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_result;
          err_d    = 1'b0;
          oe_d     = 1'b0;
          state_d  = STATE_RESP;
          if (upd_q) begin
            // Logic ops produce no meaningful carry/overflow, so those bits are cleared.
            flags_d = func_arith ?
                      {alu_zero_flag, alu_positive_flag, alu_carry_flag, alu_signed_overflow} :
                      {alu_zero_flag, alu_positive_flag, 2'b00};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STATE_RESP: begin
        if (rsp_ready) begin
          state_d = STATE_IDLE;
        end
      end
      default: ;
    endcase

    // A new request can arrive from IDLE or in the same edge a response is consumed.
    if (accept) begin
      a_d    = req_a;
      b_d    = req_b;
      func_d = req_func;
      upd_d  = req_update_flags;
      if (func_legal) begin
        state_d = STATE_DRIVE;
        cnt_d   = CNT_INIT;
        oe_d    = 1'b1;
      end else begin
        state_d  = STATE_RESP;
        oe_d     = 1'b0;
        result_d = '0;
        err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STATE_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= FUNC_ADD;
      upd_q    <= 1'b0;
      oe_q     <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      func_q   <= func_d;
      upd_q    <= upd_d;
      oe_q     <= oe_d;
      result_q <= result_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
    end
  end

  assign alu_operand_a     = a_q;
  assign alu_operand_b     = b_q;
  assign alu_func          = func_q;
  assign alu_output_enable = oe_q;
  assign rsp_valid         = (state_q == STATE_RESP);
  assign rsp_result        = result_q;
  assign rsp_err           = err_q;
  assign busy              = (state_q != STATE_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: an ALU stub answers on the bus, a reference model
// predicts each response at acceptance, and a negedge monitor checks every response cycle.
module tb_alu_op_sequencer;
  localparam int DW = 8;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a, req_b;
  logic [3:0]    req_func;
  logic          req_update_flags;
  logic [DW-1:0] alu_operand_a, alu_operand_b;
  logic [3:0]    alu_func;
  logic          alu_output_enable;
  logic [DW-1:0] alu_result;
  logic          alu_zero_flag, alu_positive_flag, alu_carry_flag, alu_signed_overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_err;
  logic [3:0]    flags_q;
  logic          busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func), .req_update_flags(req_update_flags),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_func(alu_func), .alu_output_enable(alu_output_enable),
    .alu_result(alu_result), .alu_zero_flag(alu_zero_flag),
    .alu_positive_flag(alu_positive_flag), .alu_carry_flag(alu_carry_flag),
    .alu_signed_overflow(alu_signed_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .flags_q(flags_q), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    logic [3:0]    flags;
    int            acc;
    int            lat;
    int            oe_exp;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       head;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         oe_cnt = 0;
  bit         start_chk = 0;
  logic [3:0] model_flags = 4'd0;

  logic [DW-1:0] junk;
  logic [3:0]    junkf;
  logic          rr_rand, rr_force, rr_val;
  logic [DW+3:0] ev;

  assign rsp_ready = rr_force ? rr_val : rr_rand;

  // Reference ALU: {result, Z, P, C, O}; P means strictly positive.
  function automatic logic [DW+3:0] alu_eval(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] f);
    logic [DW:0]   w;
    logic [DW-1:0] r;
    logic          c, o;
    c = 1'b0; o = 1'b0; w = '0;
    case (f)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[DW-1:0]; c = w[DW];
        o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~a;
      default: r = '0;
    endcase
    return {r, (r == '0), (!r[DW-1] && (r != '0)), c, o};
  endfunction

  // ALU stub: garbage on the bus when not enabled; junk C/O for logic ops.
  always_comb begin
    ev = alu_eval(alu_operand_a, alu_operand_b, alu_func);
    if (alu_output_enable) begin
      alu_result        = ev[DW+3:4];
      alu_zero_flag     = ev[3];
      alu_positive_flag = ev[2];
      if (alu_func <= 4'd1) {alu_carry_flag, alu_signed_overflow} = ev[1:0];
      else                  {alu_carry_flag, alu_signed_overflow} = junkf[1:0];
    end else begin
      alu_result = junk;
      {alu_zero_flag, alu_positive_flag, alu_carry_flag, alu_signed_overflow} = junkf;
    end
  end

  initial begin
    junk = '0; junkf = '0; rr_rand = 1'b0;
    forever begin
      @(posedge clk); #1;
      junk    = DW'($urandom);
      junkf   = 4'($urandom);
      rr_rand = 1'($urandom_range(0, 1));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_push();
    exp_t          e;
    logic [DW+3:0] r;
    r     = alu_eval(req_a, req_b, req_func);
    e.acc = cyc;
    if (req_func <= 4'd5) begin
      e.res = r[DW+3:4]; e.err = 1'b0; e.lat = S + 1; e.oe_exp = S;
      if (req_update_flags)
        model_flags = (req_func <= 4'd1) ? r[3:0] : {r[3:2], 2'b00};
    end else begin
      e.res = '0; e.err = 1'b1; e.lat = 1; e.oe_exp = 0;
    end
    e.flags = model_flags;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(sb_q.size() != 0));
      if (sb_q.size() == 0) chk("req_ready_idle", 32'(req_ready), 32'd1);
      if (alu_output_enable) oe_cnt++;
      if (rsp_valid) begin
        chk("oe_released", 32'(alu_output_enable), 32'd0);
        if (sb_q.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          head = sb_q[0];
          if (!start_chk) begin
            chk("latency", 32'(cyc - head.acc), 32'(head.lat));
            start_chk = 1;
          end
          chk("rsp_result", 32'(rsp_result), 32'(head.res));
          chk("rsp_err", 32'(rsp_err), 32'(head.err));
          chk("flags", 32'(flags_q), 32'(head.flags));
          if (!rsp_ready) begin
            chk("req_ready_blocked", 32'(req_ready), 32'd0);
          end else begin
            chk("oe_cycles", 32'(oe_cnt), 32'(head.oe_exp));
            void'(sb_q.pop_front());
            start_chk = 0;
            oe_cnt    = 0;
          end
        end
      end
      if (req_valid && req_ready) begin
        $display("txn: a=%0h b=%0h func=%0d upd=%0b accepted at cycle %0d",
                 req_a, req_b, req_func, req_update_flags, cyc);
        model_push();
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f,
                      input logic u);
    bit ok;
    ok = 0;
    req_a = a; req_b = b; req_func = f; req_update_flags = u; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = DW'($urandom); req_b = DW'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_func = '0;
    req_update_flags = 1'b0; rr_force = 1'b1; rr_val = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe", 32'(alu_output_enable), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_func", 32'(alu_func), 32'd0);
    chk("rst_operands", 32'({alu_operand_a, alu_operand_b}), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    send(8'h7F, 8'h01, 4'd0, 1'b1);
    wait_idle();
    send(8'hFF, 8'h01, 4'd0, 1'b1);
    send(8'hAA, 8'h55, 4'd2, 1'b1);
    wait_idle();

    // Response back-pressure: result must hold while the consumer stalls.
    @(posedge clk); #1; rr_val = 1'b0;
    send(8'h10, 8'h20, 4'd0, 1'b1);
    wait_rsp();
    repeat (5) @(negedge clk);
    @(posedge clk); #1; rr_val = 1'b1;
    wait_idle();

    // Response consumed and next request accepted on the same edge.
    @(posedge clk); #1; rr_val = 1'b0;
    send(8'h33, 8'h44, 4'd1, 1'b1);
    wait_rsp();
    @(posedge clk); #1;
    rr_val = 1'b1;
    req_a = 8'hF0; req_b = 8'h0F; req_func = 4'd4; req_update_flags = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    chk("b2b_accept", 32'(req_ready && rsp_valid), 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    wait_idle();

    send(8'h12, 8'h34, 4'hC, 1'b1);
    wait_idle();

    rr_force = 1'b0;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(DW'($urandom), DW'($urandom), 4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
    end
    rr_force = 1'b1; rr_val = 1'b1;
    wait_idle();

    // Asynchronous reset in the middle of DRIVE discards the operation.
    send(8'h7F, 8'h01, 4'd0, 1'b1);
    wait_idle();
    chk("pre_reset_flags", 32'(flags_q), 32'(model_flags));
    @(posedge clk); #1;
    send(8'h10, 8'h20, 4'd0, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_oe", 32'(alu_output_enable), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_flags", 32'(flags_q), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    sb_q.delete();
    model_flags = 4'd0; start_chk = 0; oe_cnt = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    send(8'h05, 8'h03, 4'd1, 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle sequencer wrapped around the tri-stated ALU.
- Accepts ALU operation requests over a valid/ready handshake and drives the ALU's operand, function and output_enable inputs.
- Waits a parameterised settle time, then captures alu_result and flags into a result register and the CPU status (flags) register.
- Returns the result over a second valid/ready handshake.
- Sits between the control/decode stage and the ALU, and owns the ALU's output_enable so the shared data bus is released outside operations.

Parameters:
- DATA_W, 8, operand/result width.
- SETTLE_CYCLES, 1, cycles output_enable is held before capture; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid at the clk edge.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- req_func  in  alu_func_e  ALU function (alu_pkg).
- req_update_flags  in  1  1 = write flags_q on completion.
- alu_operand_a  out  DATA_W  to ALU operand_a.
- alu_operand_b  out  DATA_W  to ALU operand_b.
- alu_func  out  alu_func_e  to ALU alu_func.
- alu_output_enable  out  1  to ALU output_enable.
- alu_result  in  DATA_W  ALU result (shared bus).
- alu_zero_flag, alu_positive_flag, alu_carry_flag, alu_signed_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_result  out  DATA_W  captured result.
- rsp_err  out  1  response is for an illegal func.
- flags_q  out  4  status register {Z,P,C,O}.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, mid-operation included.
  - State goes to IDLE, settle counter to 0.
  - alu_operand_a/b = 0, alu_func = ADD, alu_output_enable = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_err = 0, flags_q = 0, busy = 0.
  - req_ready = 0 while reset is high.
  - Any in-flight operation is discarded and no response is produced.
- States: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid&req_ready, register req_a/b/func/update_flags into the ALU drive regs.
  - If func is legal (ADD, SUB, AND, OR, XOR, INV): go to DRIVE with counter = SETTLE_CYCLES-1.
  - If func is illegal: go directly to RESP with rsp_result = 0, rsp_err = 1, flags unchanged; ALU is never enabled.
- DRIVE:
  - alu_output_enable = 1 (registered, high for exactly SETTLE_CYCLES cycles).
  - Counter decrements each cycle.
  - At the edge where counter == 0: capture alu_result into rsp_result, set rsp_err = 0, update flags if enabled, go to RESP.
- RESP:
  - rsp_valid = 1; alu_output_enable = 0.
  - rsp_result and rsp_err are held stable until rsp_valid&rsp_ready.
  - On rsp_ready with no new request: go to IDLE.
- Back-to-back:
  - req_ready = (state==IDLE) | (state==RESP & rsp_ready).
  - If rsp_ready and req_valid coincide in RESP, the new request is accepted the same edge and the FSM goes straight to DRIVE (or RESP if illegal).
- Latency (SETTLE_CYCLES = 1): request accepted at edge N, alu_output_enable high in cycle N+1, rsp_valid high from cycle N+2. Generally rsp_valid is high SETTLE_CYCLES+1 cycles after acceptance.
- Flags, written at the capture edge only, when update_flags was latched as 1:
  - ADD/SUB: Z, P, C, O copied from the ALU flag inputs.
  - AND/OR/XOR/INV: Z and P copied; C and O cleared to 0.
  - update_flags = 0, or illegal func: flags_q unchanged.
- ALU drive regs hold their last values after an operation; only output_enable is released.
- busy = 1 in DRIVE and RESP.

Test Plan:
- Reset then ADD, a=7F, b=01, update=1, SETTLE_CYCLES=1 -> alu_output_enable high exactly 1 cycle; rsp_valid 2 cycles after accept; rsp_result=80; flags_q={Z0,P0,C0,O1}.
- ADD FF+01 (update=1), then AND AA&55 (update=1) -> first flags_q={1,0,1,0} with result 00; second result 00 with flags_q={1,0,0,0} (C cleared).
- ADD 10+20 with rsp_ready low 5 cycles -> rsp_valid held; rsp_result=30 stable; req_ready=0; alu_output_enable=0 throughout the wait.
- In RESP, drive rsp_ready=1 and req_valid=1 (XOR F0^0F, update=0) in the same cycle -> accepted that edge; next rsp_result=FF; flags_q unchanged from prior op.
- Assert reset during DRIVE, with SETTLE_CYCLES=4 build and the op 2 cycles into DRIVE -> alu_output_enable, busy and flags_q go to 0 immediately; no rsp_valid after reset release; req_ready=1 the first cycle after release.
- Illegal func encoding -> alu_output_enable never high; rsp_valid 1 cycle after accept; rsp_err=1; rsp_result=00; flags_q unchanged.
